// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state type and index helpers for the twiddle sequencer
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DONE
    } seq_state_t;

    localparam int MAX_IW = 10;

    // Reverses the low 'width' bits of k; bits above width are returned as zero.
    function automatic logic [MAX_IW-1:0] bitrev(input logic [MAX_IW-1:0] k, input int width);
        logic [MAX_IW-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_IW; i++) begin
            if (i < width) r[i] = k[width-1-i];
        end
        return r;
    endfunction

    function automatic int entry_offset(input int k, input int n, input int nbits);
        return (n - 1 - k) * 2 * nbits;
    endfunction

endpackage

// File: rtl/fft_coeff_mux.sv
// rtl/fft_coeff_mux.sv - selects one complex entry from the packed ROM bus and splits re/im
module fft_coeff_mux
    import fft_pkg::*;
#(
    parameter int NBITS = 11,
    parameter int N     = 32,
    parameter int IW    = $clog2(N)
) (
    input  logic [NBITS*N*2-1:0] coeff_data,
    input  logic [IW-1:0]        idx,
    output logic [NBITS-1:0]     re,
    output logic [NBITS-1:0]     im
);

    logic [2*NBITS-1:0] entries [N];
    logic [2*NBITS-1:0] entry;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign entries[g] = coeff_data[entry_offset(g, N, NBITS) +: 2*NBITS];
    end

    always_comb begin
        entry = entries[idx];
        re    = entry[2*NBITS-1:NBITS];
        im    = entry[NBITS-1:0];
    end

endmodule

// File: rtl/fft_twiddle_sequencer.sv
// rtl/fft_twiddle_sequencer.sv - streams twiddles over len entries x passes; FFT_TWID_BITREV_EN selects bit-reversed order
module fft_twiddle_sequencer
    import fft_pkg::*;
#(
    parameter int NBITS = 11,
    parameter int N     = 32,
    parameter int IW    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NBITS*N*2-1:0] coeff_data,
    input  logic                 start,
    input  logic [IW:0]          len,
    input  logic [7:0]           passes,
    input  logic                 abort,
    output logic [NBITS-1:0]     tw_re,
    output logic [NBITS-1:0]     tw_im,
    output logic [IW-1:0]        tw_idx,
    output logic                 tw_last,
    output logic                 tw_valid,
    input  logic                 tw_ready,
    output logic                 busy,
    output logic                 done
);

    seq_state_t       state;
    logic [IW-1:0]    k;
    logic [7:0]       p;
    logic [IW:0]      len_q;
    logic [7:0]       passes_q;

    logic [IW:0]      len_eff;
    logic [7:0]       passes_eff;
    logic [IW:0]      len_lim;
    logic             k_end;
    logic             p_end;
    logic             accept;
    logic [IW-1:0]    load_k;
    logic [IW-1:0]    load_idx;
    logic             load_last;
    logic [NBITS-1:0] mux_re;
    logic [NBITS-1:0] mux_im;

    always_comb begin
        len_eff    = (len == '0 || len > (IW+1)'(N)) ? (IW+1)'(N) : len;
        passes_eff = (passes == 8'd0) ? 8'd1 : passes;
        k_end      = ({1'b0, k} == len_q - 1'b1);
        p_end      = (p == passes_q - 8'd1);
        accept     = tw_valid && tw_ready;
        // The mux always looks at the entry that would be loaded on the next edge.
        load_k     = (state == ST_ISSUE && !k_end) ? k + 1'b1 : '0;
        len_lim    = (state == ST_IDLE) ? len_eff : len_q;
        load_last  = ({1'b0, load_k} == len_lim - 1'b1);
    end

`ifdef FFT_TWID_BITREV_EN
    assign load_idx = IW'(bitrev(MAX_IW'(load_k), IW));
`else
    assign load_idx = load_k;
`endif

    fft_coeff_mux #(
        .NBITS (NBITS),
        .N     (N),
        .IW    (IW)
    ) u_mux (
        .coeff_data (coeff_data),
        .idx        (load_idx),
        .re         (mux_re),
        .im         (mux_im)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            k        <= '0;
            p        <= '0;
            len_q    <= '0;
            passes_q <= '0;
            tw_re    <= '0;
            tw_im    <= '0;
            tw_idx   <= '0;
            tw_last  <= 1'b0;
            tw_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (abort) begin
            state    <= ST_IDLE;
            tw_valid <= 1'b0;
            tw_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        len_q    <= len_eff;
                        passes_q <= passes_eff;
                        k        <= '0;
                        p        <= '0;
                        tw_re    <= mux_re;
                        tw_im    <= mux_im;
                        tw_idx   <= load_idx;
                        tw_last  <= load_last;
                        tw_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (accept) begin
                        if (k_end && p_end) begin
                            tw_valid <= 1'b0;
                            tw_last  <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            if (k_end) p <= p + 8'd1;
                            k       <= load_k;
                            tw_re   <= mux_re;
                            tw_im   <= mux_im;
                            tw_idx  <= load_idx;
                            tw_last <= load_last;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    tw_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
